// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Opcodes, sequencer state, writeback-select and fault encodings
//            shared by the multi-cycle sequencer and its opcode decoder.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam logic [6:0] c_op_r      = 7'h33;
  localparam logic [6:0] c_op_i      = 7'h13;
  localparam logic [6:0] c_op_load   = 7'h03;
  localparam logic [6:0] c_op_store  = 7'h23;
  localparam logic [6:0] c_op_branch = 7'h63;
  localparam logic [6:0] c_op_jal    = 7'h6F;
  localparam logic [6:0] c_op_jalr   = 7'h67;
  localparam logic [6:0] c_op_lui    = 7'h37;
  localparam logic [6:0] c_op_auipc  = 7'h17;
  localparam logic [6:0] c_op_system = 7'h73;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_RSVD = 2'd3
  } wb_sel_t;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'd0,
    FAULT_ILLEGAL = 2'd1,
    FAULT_TIMEOUT = 2'd2
  } fault_t;

  // One-hot instruction class; all-zero means the opcode is not recognised.
  typedef struct packed {
    logic r;
    logic i;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic lui;
    logic auipc;
    logic system;
  } opclass_t;

endpackage
`default_nettype wire

// File: rtl/riscv_opclass_decoder.sv
`default_nettype none
// ============================================================================
// Module   : riscv_opclass_decoder
// Brief    : Combinational RV32I major-opcode classifier (one-hot + illegal).
// Revision : 1.0 - initial release
// ============================================================================
module riscv_opclass_decoder
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output opclass_t   cls,
  output logic       illegal
);

  always_comb begin
    cls = '0;
    case (opcode)
      c_op_r:      cls.r      = 1'b1;
      c_op_i:      cls.i      = 1'b1;
      c_op_load:   cls.load   = 1'b1;
      c_op_store:  cls.store  = 1'b1;
      c_op_branch: cls.branch = 1'b1;
      c_op_jal:    cls.jal    = 1'b1;
      c_op_jalr:   cls.jalr   = 1'b1;
      c_op_lui:    cls.lui    = 1'b1;
      c_op_auipc:  cls.auipc  = 1'b1;
      c_op_system: cls.system = 1'b1;
      default:     cls        = '0;
    endcase
  end

  assign illegal = (cls == '0);

endmodule
`default_nettype wire

// File: rtl/riscv_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : riscv_multicycle_sequencer
// Brief    : Multi-cycle RV32I control FSM owning PC, IR, fault and retire count.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_multicycle_sequencer
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          MEM_TIMEOUT = 16,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [31:0]      inst,
  output logic [31:0]      inst_addr,
  output logic [31:0]      ir,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  output logic             mem_req,
  output logic             mem_write_en,
  input  logic             mem_ready,
  output logic             rd_we,
  output logic [1:0]       wb_sel,
  output logic             halted,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] retired
);

  localparam int c_tmo_w = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(MEM_TIMEOUT - 1);

  seq_state_t         r_state, w_next_state;
  logic [31:0]        r_pc, w_next_pc;
  logic [31:0]        r_ir;
  fault_t             r_fault, w_next_fault;
  logic [CNT_W-1:0]   r_retired;
  logic [c_tmo_w-1:0] r_tmo_cnt, w_next_tmo;
  logic               w_retire;
  logic [31:0]        w_pc_plus4;
  opclass_t           w_cls;
  logic               w_illegal;
  wb_sel_t            w_wb_sel;

  riscv_opclass_decoder u_decoder (
    .opcode  (r_ir[6:0]),
    .cls     (w_cls),
    .illegal (w_illegal)
  );

  assign w_pc_plus4 = r_pc + 32'd4;

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_fault = r_fault;
    w_next_tmo   = r_tmo_cnt;
    w_retire     = 1'b0;
    case (r_state)
      S_FETCH: w_next_state = S_DECODE;
      S_DECODE: begin
        if (w_illegal) begin
          w_next_state = S_HALT;
          w_next_fault = FAULT_ILLEGAL;
        end else if (w_cls.system) begin
          // SYSTEM retires as it stops the core.
          w_next_state = S_HALT;
          w_retire     = 1'b1;
        end else begin
          w_next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_cls.branch) begin
          w_next_pc    = branch_taken ? branch_target : w_pc_plus4;
          w_retire     = 1'b1;
          w_next_state = S_FETCH;
        end else if (w_cls.load || w_cls.store) begin
          w_next_tmo   = '0;
          w_next_state = S_MEM;
        end else begin
          w_next_state = S_WB;
        end
      end
      S_MEM: begin
        // A completion on the final allowed cycle is still honoured.
        if (mem_ready) begin
          w_next_tmo = '0;
          if (w_cls.store) begin
            w_next_pc    = w_pc_plus4;
            w_retire     = 1'b1;
            w_next_state = S_FETCH;
          end else begin
            w_next_state = S_WB;
          end
        end else if (r_tmo_cnt == c_tmo_last) begin
          w_next_state = S_HALT;
          w_next_fault = FAULT_TIMEOUT;
        end else begin
          w_next_tmo = r_tmo_cnt + c_tmo_w'(1);
        end
      end
      S_WB: begin
        w_next_pc    = (w_cls.jal || w_cls.jalr) ? {branch_target[31:1], 1'b0} : w_pc_plus4;
        w_retire     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_HALT: w_next_state = S_HALT;
      default: w_next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_fault   <= FAULT_NONE;
      r_retired <= '0;
      r_tmo_cnt <= '0;
    end else begin
      r_state   <= w_next_state;
      r_pc      <= w_next_pc;
      r_fault   <= w_next_fault;
      r_tmo_cnt <= w_next_tmo;
      if (r_state == S_FETCH) r_ir <= inst;
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    w_wb_sel = WB_ALU;
    if (r_state == S_WB) begin
      if (w_cls.load)                    w_wb_sel = WB_LOAD;
      else if (w_cls.jal || w_cls.jalr)  w_wb_sel = WB_PC4;
    end
  end

  // Strobes are forced low while reset is asserted, even before the edge.
  assign mem_req      = !rst_b && (r_state == S_MEM);
  assign mem_write_en = mem_req && w_cls.store;
  assign rd_we        = !rst_b && (r_state == S_WB) && (r_ir[11:7] != 5'd0);
  assign wb_sel       = w_wb_sel;
  assign inst_addr    = r_pc;
  assign ir           = r_ir;
  assign halted       = (r_state == S_HALT);
  assign fault        = r_fault;
  assign retired      = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_riscv_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_multicycle_sequencer
// Brief    : Directed table-driven bench for the multi-cycle sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst_b = 1'b1;
  logic [31:0] inst = '0;
  logic [31:0] inst_addr;
  logic [31:0] ir;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        mem_req;
  logic        mem_write_en;
  logic        mem_ready = 1'b0;
  logic        rd_we;
  logic [1:0]  wb_sel;
  logic        halted;
  logic [1:0]  fault;
  logic [31:0] retired;

  int n_tests = 0;
  int n_fail  = 0;

  riscv_multicycle_sequencer #(
    .RESET_PC    (32'h100),
    .MEM_TIMEOUT (4),
    .CNT_W       (32)
  ) dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .inst          (inst),
    .inst_addr     (inst_addr),
    .ir            (ir),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .mem_req       (mem_req),
    .mem_write_en  (mem_write_en),
    .mem_ready     (mem_ready),
    .rd_we         (rd_we),
    .wb_sel        (wb_sel),
    .halted        (halted),
    .fault         (fault),
    .retired       (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic        taken;
    logic [31:0] target;
    int          waits;     // ready-low MEM cycles; -1 = never ready
    int          lat;
    logic [31:0] pc;
    int          rdwe_cyc;  // 0 = rd_we never asserted
    logic [1:0]  wbsel;
    int          mrq;
    int          mwe;
    logic        halt;
    logic [1:0]  fault;
    logic [31:0] ret;
  } vec_t;

  localparam int NV = 15;
  vec_t tv[NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_b     = 1'b1;
    mem_ready = 1'b0;
    tick();
    tick();
    rst_b = 1'b0;
  endtask

  initial begin
    int lat, rdwe_cyc, rdwe_cnt, mrq, mwe, mseen, strobes;
    logic [1:0]  wbs;
    logic [31:0] pc0, ret0;

    //            name        inst          tk    target        wt  lat pc            rdwe wbs  mrq mwe hlt  flt  ret
    tv[0]  = '{"addi",      32'h00500093, 1'b0, 32'h0,        0,  4, 32'h104,       4, 2'd0, 0, 0, 1'b0, 2'd0, 32'd1};
    tv[1]  = '{"addi_x0",   32'h00500013, 1'b0, 32'h0,        0,  4, 32'h104,       0, 2'd0, 0, 0, 1'b0, 2'd0, 32'd1};
    tv[2]  = '{"beq_tk",    32'h00000063, 1'b1, 32'h200,      0,  3, 32'h200,       0, 2'd0, 0, 0, 1'b0, 2'd0, 32'd1};
    tv[3]  = '{"beq_nt",    32'h00000063, 1'b0, 32'h200,      0,  3, 32'h104,       0, 2'd0, 0, 0, 1'b0, 2'd0, 32'd1};
    tv[4]  = '{"lw_w3",     32'h00002103, 1'b0, 32'h0,        3,  8, 32'h104,       8, 2'd1, 4, 0, 1'b0, 2'd0, 32'd1};
    tv[5]  = '{"lw_w0",     32'h00002103, 1'b0, 32'h0,        0,  5, 32'h104,       5, 2'd1, 1, 0, 1'b0, 2'd0, 32'd1};
    tv[6]  = '{"lw_tmo",    32'h00002103, 1'b0, 32'h0,       -1,  7, 32'h100,       0, 2'd0, 4, 0, 1'b1, 2'd2, 32'd0};
    tv[7]  = '{"sw_w0",     32'h00112023, 1'b0, 32'h0,        0,  4, 32'h104,       0, 2'd0, 1, 1, 1'b0, 2'd0, 32'd1};
    tv[8]  = '{"sw_w2",     32'h00112023, 1'b0, 32'h0,        2,  6, 32'h104,       0, 2'd0, 3, 3, 1'b0, 2'd0, 32'd1};
    tv[9]  = '{"jal",       32'h008000EF, 1'b0, 32'h301,      0,  4, 32'h300,       4, 2'd2, 0, 0, 1'b0, 2'd0, 32'd1};
    tv[10] = '{"jalr_x0",   32'h00008067, 1'b0, 32'h2FF,      0,  4, 32'h2FE,       0, 2'd2, 0, 0, 1'b0, 2'd0, 32'd1};
    tv[11] = '{"lui",       32'h123452B7, 1'b0, 32'h0,        0,  4, 32'h104,       4, 2'd0, 0, 0, 1'b0, 2'd0, 32'd1};
    tv[12] = '{"ecall",     32'h00000073, 1'b0, 32'h0,        0,  2, 32'h100,       0, 2'd0, 0, 0, 1'b1, 2'd0, 32'd1};
    tv[13] = '{"illegal",   32'h0000007F, 1'b0, 32'h0,        0,  2, 32'h100,       0, 2'd0, 0, 0, 1'b1, 2'd1, 32'd0};
    tv[14] = '{"add",       32'h002081B3, 1'b0, 32'h0,        0,  4, 32'h104,       4, 2'd0, 0, 0, 1'b0, 2'd0, 32'd1};

    // Reset state, observed while reset is still held.
    inst = 32'h00500093;
    rst_b = 1'b1;
    tick();
    tick();
    check("rst.pc", inst_addr, 32'h100);
    check("rst.ir", ir, 32'h0);
    check("rst.halted", {31'd0, halted}, 32'd0);
    check("rst.fault", {30'd0, fault}, 32'd0);
    check("rst.retired", retired, 32'd0);
    check("rst.strobes", {29'd0, mem_req, mem_write_en, rd_we}, 32'd0);
    rst_b = 1'b0;
    tick();
    check("rst.first_fetch_ir", ir, 32'h00500093);

    for (int k = 0; k < NV; k++) begin
      do_reset();
      inst          = tv[k].inst;
      branch_taken  = tv[k].taken;
      branch_target = tv[k].target;
      pc0 = inst_addr; ret0 = retired;
      lat = 0; rdwe_cyc = 0; rdwe_cnt = 0; mrq = 0; mwe = 0; mseen = 0; wbs = 2'd0;
      for (int c = 1; c <= 30 && lat == 0; c++) begin
        if (rd_we) begin
          rdwe_cnt++;
          if (rdwe_cyc == 0) rdwe_cyc = c;
        end
        wbs = wbs | wb_sel;
        if (mem_req) begin
          mrq++;
          mseen++;
          if (mem_write_en) mwe++;
        end
        mem_ready = (tv[k].waits >= 0) && (mseen > tv[k].waits);
        tick();
        if (inst_addr != pc0 || retired != ret0 || halted) lat = c;
      end
      mem_ready = 1'b0;
      check({tv[k].name, ".lat"},      lat,               tv[k].lat);
      check({tv[k].name, ".pc"},       inst_addr,         tv[k].pc);
      check({tv[k].name, ".rdwe_cyc"}, rdwe_cyc,          tv[k].rdwe_cyc);
      check({tv[k].name, ".rdwe_cnt"}, rdwe_cnt,          (tv[k].rdwe_cyc != 0) ? 1 : 0);
      check({tv[k].name, ".wb_sel"},   {30'd0, wbs},      {30'd0, tv[k].wbsel});
      check({tv[k].name, ".mem_req"},  mrq,               tv[k].mrq);
      check({tv[k].name, ".mem_we"},   mwe,               tv[k].mwe);
      check({tv[k].name, ".halted"},   {31'd0, halted},   {31'd0, tv[k].halt});
      check({tv[k].name, ".fault"},    {30'd0, fault},    {30'd0, tv[k].fault});
      check({tv[k].name, ".retired"},  retired,           tv[k].ret);
      if (tv[k].halt) begin
        // HALT must absorb further input with no side effects.
        inst = 32'h00500093;
        mem_ready = 1'b1;
        strobes = 0;
        repeat (4) begin
          tick();
          strobes += int'(mem_req) + int'(mem_write_en) + int'(rd_we);
        end
        mem_ready = 1'b0;
        check({tv[k].name, ".halt_strobes"}, strobes, 0);
        check({tv[k].name, ".halt_pc"},      inst_addr, tv[k].pc);
        check({tv[k].name, ".halt_ret"},     retired, tv[k].ret);
        check({tv[k].name, ".halt_ir"},      ir, tv[k].inst);
        check({tv[k].name, ".halt_sticky"},  {30'd0, fault}, {30'd0, tv[k].fault});
      end
    end

    // Reset asserted in the middle of a MEM wait.
    do_reset();
    inst = 32'h00002103;
    branch_taken = 1'b0;
    repeat (3) tick();
    check("midmem.req_before", {31'd0, mem_req}, 32'd1);
    rst_b = 1'b1;
    #1;
    check("midmem.req_during", {31'd0, mem_req}, 32'd0);
    tick();
    check("midmem.req_after", {31'd0, mem_req}, 32'd0);
    check("midmem.pc", inst_addr, 32'h100);
    check("midmem.halted", {31'd0, halted}, 32'd0);
    rst_b = 1'b0;

    // PC wrap and retire accumulation across several instructions.
    do_reset();
    inst = 32'h0000006F;            // jal x0
    branch_target = 32'hFFFFFFFC;
    repeat (4) tick();
    check("seq.jal_pc", inst_addr, 32'hFFFFFFFC);
    inst = 32'h00500093;            // addi x1,x0,5
    repeat (4) tick();
    check("seq.wrap_pc", inst_addr, 32'h0);
    check("seq.ret2", retired, 32'd2);
    inst = 32'h00000063;            // beq taken
    branch_taken = 1'b1;
    branch_target = 32'h40;
    repeat (3) tick();
    check("seq.beq_pc", inst_addr, 32'h40);
    check("seq.ret3", retired, 32'd3);
    branch_taken = 1'b0;
    inst = 32'h00000073;            // ecall
    repeat (2) tick();
    check("seq.ecall_halt", {31'd0, halted}, 32'd1);
    check("seq.ret4", retired, 32'd4);
    inst = 32'h00500093;
    repeat (5) tick();
    check("seq.frozen_pc", inst_addr, 32'h40);
    check("seq.frozen_ret", retired, 32'd4);
    check("seq.frozen_ir", ir, 32'h00000073);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
